// File: rtl/ula_pkg.sv
// Shared ULA datapath types: operand/counter widths, divider front-end FSM states, requester id.
package ula_pkg;
  localparam int A_W   = 5;
  localparam int B_W   = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic id_t;
endpackage

// File: rtl/divisao_5por4.sv
// Combinational 5-bit by 4-bit quotient core; a zero divisor yields a zero quotient.
module divisao_5por4 (
  input  logic [4:0] a,
  input  logic [3:0] b,
  output logic [4:0] s
);
  // Quotient with the zero-divisor case forced to 0
  always_comb begin
    s = 5'd0;
    if (b == 4'd0) begin
      s = 5'd0;
    end else begin
      s = a / {1'b0, b};
    end
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: the pointer only matters when both requesters are valid.
module rr_arb2
  import ula_pkg::*;
(
  input  logic [1:0] i_valid,
  input  id_t        i_rr,
  output logic [1:0] o_gnt,
  output id_t        o_gnt_id
);
  // Grant selection from valid pattern and pointer
  always_comb begin
    o_gnt    = 2'b00;
    o_gnt_id = 1'b0;
    case (i_valid)
      2'b01: begin
        o_gnt    = 2'b01;
        o_gnt_id = 1'b0;
      end
      2'b10: begin
        o_gnt    = 2'b10;
        o_gnt_id = 1'b1;
      end
      2'b11: begin
        o_gnt    = i_rr ? 2'b10 : 2'b01;
        o_gnt_id = i_rr;
      end
      default: begin
        o_gnt    = 2'b00;
        o_gnt_id = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/div_arbiter_2ch.sv
// Two-requester round-robin front-end for the shared 5/4 divider core.
// Build option: DIV_ZERO_FLAG_EN adds the registered divide-by-zero flag (dz tied low otherwise).
module div_arbiter_2ch
  import ula_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [A_W-1:0]   a0,
  input  logic [A_W-1:0]   a1,
  input  logic [B_W-1:0]   b0,
  input  logic [B_W-1:0]   b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [A_W-1:0]   s,
  output logic             dz,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  id_t              r_id;
  id_t              r_rr;
  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;
  logic [A_W-1:0]   r_s;
  logic [1:0]       r_rsp_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_gnt;
  id_t              w_gnt_id;
  logic [A_W-1:0]   w_q;
  logic [1:0]       w_req_ready;

  rr_arb2 u_arb (
    .i_valid  (req_valid),
    .i_rr     (r_rr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  divisao_5por4 u_core (
    .a (r_a),
    .b (r_b),
    .s (w_q)
  );

  // Requests are only accepted in IDLE, never while a result is outstanding
  always_comb begin
    w_req_ready = 2'b00;
    if (r_state == IDLE) begin
      w_req_ready = w_gnt;
    end else begin
      w_req_ready = 2'b00;
    end
  end

  // Main FSM: accept, compute, hold result until the winner takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_id        <= 1'b0;
      r_rr        <= 1'b0;
      r_a         <= {A_W{1'b0}};
      r_b         <= {B_W{1'b0}};
      r_s         <= {A_W{1'b0}};
      r_rsp_valid <= 2'b00;
      r_busy      <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_id    <= w_gnt_id;
            r_a     <= w_gnt_id ? a1 : a0;
            r_b     <= w_gnt_id ? b1 : b0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_s         <= w_q;
          r_rsp_valid <= r_id ? 2'b10 : 2'b01;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[r_id]) begin
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
            r_rr        <= ~r_id;
            r_rsp_valid <= 2'b00;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic r_dz;

  // Zero-divisor flag captured alongside the quotient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dz <= 1'b0;
    end else if (r_state == CALC) begin
      r_dz <= (r_b == {B_W{1'b0}});
    end
  end

  assign dz = r_dz;
`else
  assign dz = 1'b0;
`endif

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign s         = r_s;
  assign busy      = r_busy;
  assign op_cnt    = r_cnt;
endmodule

// File: tb/tb_div_arbiter_2ch.sv
// Directed plus randomized bench for div_arbiter_2ch against a rule-level reference model.
module tb_div_arbiter_2ch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [4:0] a0 = 5'd0, a1 = 5'd0;
  logic [3:0] b0 = 4'd0, b1 = 4'd0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b00;
  logic [4:0] s;
  logic       dz;
  logic       busy;
  logic [7:0] op_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int m_cnt = 0;
  int m_rr = 0;

  div_arbiter_2ch dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .s(s), .dz(dz), .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int id);
    return (id == 1) ? 2'b10 : 2'b01;
  endfunction

  // One transaction; entered 1 time unit after a rising edge with the DUT in IDLE.
  task automatic run_op(input logic [1:0] v, input bit keep, input int delay, input bit pre_ready);
    int win, ea, eb, eq, edz;
    req_valid = v;
    #1;
    win = (v == 2'b11) ? m_rr : (v[1] ? 1 : 0);
    ea  = win ? a1 : a0;
    eb  = win ? b1 : b0;
    eq  = (eb == 0) ? 0 : ea / eb;
`ifdef DIV_ZERO_FLAG_EN
    edz = (eb == 0) ? 1 : 0;
`else
    edz = 0;
`endif
    check("req_ready_grant", req_ready, onehot(win));
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    if (!keep) req_valid = 2'b00;
    check("busy_calc", busy, 1);
    check("rsp_valid_calc", rsp_valid, 0);
    check("req_ready_calc", req_ready, 0);
    rsp_ready = pre_ready ? onehot(win) : 2'b00;
    rsp_ready[1 - win] = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    check("rsp_valid", rsp_valid, onehot(win));
    check("s", s, eq);
    check("dz", dz, edz);
    if (!pre_ready) begin
      for (int i = 0; i < delay; i++) begin
        @(posedge clk);
        #1;
        check("rsp_valid_hold", rsp_valid, onehot(win));
        check("s_hold", s, eq);
        check("dz_hold", dz, edz);
        check("req_ready_resp", req_ready, 0);
        check("op_cnt_hold", op_cnt, m_cnt);
      end
      rsp_ready[win] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (m_cnt < 255) m_cnt++;
    m_rr = 1 - win;
    check("rsp_valid_done", rsp_valid, 0);
    check("op_cnt", op_cnt, m_cnt);
    check("busy_idle", busy, 0);
    rsp_ready = 2'b00;
  endtask

  initial begin
    int prev;
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_s", s, 0);
    check("rst_dz", dz, 0);
    check("rst_busy", busy, 0);
    check("rst_op_cnt", op_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 0
    a0 = 5'd23; b0 = 4'd4;
    run_op(2'b01, 0, 1, 0);

    // Simultaneous requests after a fresh reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    m_cnt = 0; m_rr = 0;
    @(posedge clk); #1;
    a0 = 5'd10; b0 = 4'd3; a1 = 5'd31; b1 = 4'd2;
    run_op(2'b11, 1, 0, 1);
    run_op(2'b10, 0, 0, 1);

    // Continuous contention with rsp_ready already high: 3-cycle accept spacing
    a0 = 5'd29; b0 = 4'd7; a1 = 5'd12; b1 = 4'd5;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(2'b11, 1, 0, 1);
      if (i > 0) check("accept_spacing", acc_cyc - prev, 3);
      prev = acc_cyc;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Divide by zero on requester 1
    a1 = 5'd17; b1 = 4'd0;
    run_op(2'b10, 0, 0, 1);

    // Response stall of 5 cycles while the other requester stays valid
    a0 = 5'd30; b0 = 4'd0; a1 = 5'd25; b1 = 4'd6;
    run_op(2'b11, 1, 5, 0);
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Reset during CALC aborts the transaction
    a0 = 5'd31; b0 = 4'd1;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("busy_before_abort", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    m_cnt = 0; m_rr = 0;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_s", s, 0);
    check("abort_dz", dz, 0);
    check("abort_op_cnt", op_cnt, 0);
    check("abort_req_ready", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_abort_rsp_valid", rsp_valid, 0);
      check("post_abort_busy", busy, 0);
    end
    a1 = 5'd9; b1 = 4'd2;
    run_op(2'b10, 0, 2, 0);

    // Randomized traffic up to and past counter saturation
    while (m_cnt < 255) begin
      a0 = 5'($urandom_range(0, 31)); b0 = 4'($urandom_range(0, 15));
      a1 = 5'($urandom_range(0, 31)); b1 = 4'($urandom_range(0, 15));
      run_op(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) begin
      a0 = 5'($urandom_range(0, 31)); b0 = 4'($urandom_range(0, 15));
      a1 = 5'($urandom_range(0, 31)); b1 = 4'($urandom_range(0, 15));
      run_op(2'($urandom_range(1, 3)), 0, 1, 0);
    end
    check("op_cnt_saturated", op_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
